// File: rtl/alarm_seq_pkg.sv
// Shared types for the alarm ringing sequencer: FSM state encoding and its width.
package alarm_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE,
        RING,
        SNOOZE,
        DONE
    } alarmStateT;

endpackage

// File: rtl/sec_tick_gen.sv
// One-second tick prescaler; restart forces the count back to 0 so the first tick
// lands exactly CLK_HZ clocks after the restart cycle.
module sec_tick_gen #(
    parameter int CLK_HZ = 50000000
) (
    input  logic clk,
    input  logic RESET_n,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [CNT_W-1:0] divCnt;

    // Decoded from the register, not registered again, so expiry acts on the next edge.
    assign tick = (divCnt == CNT_W'(CLK_HZ - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            divCnt <= '0;
        end else if (restart || tick) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm ringing controller: edge-triggered alarm match, ring timeout, snooze
// countdown with a per-event limit, dismiss, and melody/LED drive.
module alarm_sequencer
    import alarm_seq_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BLINK_DIV  = 2500000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic        clk,
    input  logic        RESET_n,
    input  logic        armed,
    input  logic        clk_mode,
    input  logic [15:0] cur_time,
    input  logic [15:0] alarm_time,
    input  logic        snooze_p,
    input  logic        dismiss_p,
    output logic        melody_en,
    output logic        led,
    output logic        ringing,
    output logic        snoozing,
    output logic [1:0]  snooze_cnt
);

    localparam int SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int SEC_W   = $clog2(SEC_MAX + 1);
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    alarmStateT         state;
    logic               matchNow;
    logic               matchQ;
    logic               primed;
    logic               trig;
    logic               cancel;
    logic               tick;
    logic               secLast;
    logic               snoozeOk;
    logic               enterRing;
    logic               enterSnooze;
    logic               restart;
    logic [SEC_W-1:0]   secCnt;
    logic [BLINK_W-1:0] blinkCnt;
    logic               blinkQ;
    logic [1:0]         snoozeCntQ;

    assign matchNow = (cur_time == alarm_time);
    // primed blocks a trigger on the first edge after reset, when matchQ is not yet valid.
    assign trig     = matchNow & ~matchQ & primed & armed & clk_mode;
    assign cancel   = ~armed | ~clk_mode;
    assign secLast  = tick && (secCnt == SEC_W'(1));
    assign snoozeOk = snooze_p && (snoozeCntQ < 2'(MAX_SNOOZE));

    // Entry events mirror the FSM branches below; they restart the prescaler in the same edge.
    assign enterRing   = ((state == IDLE) && trig) ||
                         ((state == SNOOZE) && !dismiss_p && armed && secLast);
    assign enterSnooze = (state == RING) && !cancel && !dismiss_p && snoozeOk;
    assign restart     = enterRing | enterSnooze;

    sec_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_tick_gen (
        .clk     (clk),
        .RESET_n (RESET_n),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            matchQ <= 1'b0;
            primed <= 1'b0;
        end else begin
            matchQ <= matchNow;
            primed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state      <= IDLE;
            secCnt     <= '0;
            snoozeCntQ <= '0;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig) begin
                        state      <= RING;
                        secCnt     <= SEC_W'(RING_SEC);
                        snoozeCntQ <= '0;
                        ringing    <= 1'b1;
                    end
                end
                RING: begin
                    if (cancel || dismiss_p) begin
                        state   <= DONE;
                        ringing <= 1'b0;
                    end else if (snoozeOk) begin
                        state      <= SNOOZE;
                        secCnt     <= SEC_W'(SNOOZE_SEC);
                        snoozeCntQ <= snoozeCntQ + 2'd1;
                        ringing    <= 1'b0;
                        snoozing   <= 1'b1;
                    end else if (tick) begin
                        secCnt <= secCnt - SEC_W'(1);
                        if (secLast) begin
                            state   <= DONE;
                            ringing <= 1'b0;
                        end
                    end
                end
                SNOOZE: begin
                    if (dismiss_p || !armed) begin
                        state    <= DONE;
                        snoozing <= 1'b0;
                    end else if (tick) begin
                        secCnt <= secCnt - SEC_W'(1);
                        if (secLast) begin
                            state    <= RING;
                            secCnt   <= SEC_W'(RING_SEC);
                            ringing  <= 1'b1;
                            snoozing <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // Wait out the matching minute so the same event cannot retrigger.
                    if (!matchNow) begin
                        state      <= IDLE;
                        snoozeCntQ <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            blinkQ   <= 1'b0;
            blinkCnt <= '0;
        end else if (enterRing) begin
            blinkQ   <= 1'b1;
            blinkCnt <= '0;
        end else if (state == RING) begin
            if (blinkCnt == BLINK_W'(BLINK_DIV - 1)) begin
                blinkQ   <= ~blinkQ;
                blinkCnt <= '0;
            end else begin
                blinkCnt <= blinkCnt + BLINK_W'(1);
            end
        end else begin
            blinkQ   <= 1'b0;
            blinkCnt <= '0;
        end
    end

    assign melody_en  = ringing;
    assign led        = (ringing & blinkQ) | snoozing;
    assign snooze_cnt = snoozeCntQ;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed and random stimulus for alarm_sequencer, checked against a clock-counting reference model.
module tb_alarm_sequencer;

    localparam int CLK_HZ     = 10;
    localparam int BLINK_DIV  = 2;
    localparam int RING_SEC   = 3;
    localparam int SNOOZE_SEC = 4;
    localparam int MAX_SNOOZE = 2;
    localparam logic [15:0] ALARM = {8'd7, 8'd30};
    localparam logic [15:0] OTHER = {8'd7, 8'd31};

    logic        clk = 1'b0;
    logic        RESET_n = 1'b0;
    logic        armed = 1'b1;
    logic        clk_mode = 1'b1;
    logic [15:0] cur_time = OTHER;
    logic [15:0] alarm_time = ALARM;
    logic        snooze_p = 1'b0;
    logic        dismiss_p = 1'b0;
    logic        melody_en;
    logic        led;
    logic        ringing;
    logic        snoozing;
    logic [1:0]  snooze_cnt;

    int checks = 0;
    int errors = 0;

    typedef enum {QUIET, SOUNDING, PAUSED, FINISHED} modeT;
    modeT mMode;
    int   mLeft;
    int   mElapsed;
    int   mUsed;
    bit   mPrevMatch;
    bit   mPrimed;

    alarm_sequencer #(
        .CLK_HZ     (CLK_HZ),
        .BLINK_DIV  (BLINK_DIV),
        .RING_SEC   (RING_SEC),
        .SNOOZE_SEC (SNOOZE_SEC),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) dut (
        .clk        (clk),
        .RESET_n    (RESET_n),
        .armed      (armed),
        .clk_mode   (clk_mode),
        .cur_time   (cur_time),
        .alarm_time (alarm_time),
        .snooze_p   (snooze_p),
        .dismiss_p  (dismiss_p),
        .melody_en  (melody_en),
        .led        (led),
        .ringing    (ringing),
        .snoozing   (snoozing),
        .snooze_cnt (snooze_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void modelReset();
        mMode      = QUIET;
        mLeft      = 0;
        mElapsed   = 0;
        mUsed      = 0;
        mPrevMatch = 1'b0;
        mPrimed    = 1'b0;
    endfunction

    // Ring and snooze are tracked as remaining clocks; blink phase from clocks since ring start.
    function automatic void modelStep();
        bit m;
        m = (cur_time == alarm_time);
        case (mMode)
            QUIET: begin
                if (m && !mPrevMatch && mPrimed && armed && clk_mode) begin
                    mMode    = SOUNDING;
                    mLeft    = RING_SEC * CLK_HZ;
                    mElapsed = 0;
                    mUsed    = 0;
                end
            end
            SOUNDING: begin
                if (!armed || !clk_mode || dismiss_p) begin
                    mMode = FINISHED;
                end else if (snooze_p && mUsed < MAX_SNOOZE) begin
                    mMode = PAUSED;
                    mLeft = SNOOZE_SEC * CLK_HZ;
                    mUsed++;
                end else begin
                    mLeft--;
                    mElapsed++;
                    if (mLeft == 0) mMode = FINISHED;
                end
            end
            PAUSED: begin
                if (dismiss_p || !armed) begin
                    mMode = FINISHED;
                end else begin
                    mLeft--;
                    if (mLeft == 0) begin
                        mMode    = SOUNDING;
                        mLeft    = RING_SEC * CLK_HZ;
                        mElapsed = 0;
                    end
                end
            end
            FINISHED: begin
                if (!m) begin
                    mMode = QUIET;
                    mUsed = 0;
                end
            end
            default: mMode = QUIET;
        endcase
        mPrevMatch = m;
        mPrimed    = 1'b1;
    endfunction

    task automatic checkOutputs(input string tag);
        logic expRing;
        logic expLed;
        expRing = (mMode == SOUNDING);
        expLed  = (mMode == PAUSED) ||
                  (expRing && ((mElapsed / BLINK_DIV) % 2 == 0));
        check({tag, ".ringing"},    ringing,    expRing);
        check({tag, ".melody_en"},  melody_en,  expRing);
        check({tag, ".snoozing"},   snoozing,   mMode == PAUSED);
        check({tag, ".led"},        led,        expLed);
        check({tag, ".snooze_cnt"}, snooze_cnt, mUsed[1:0]);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        modelStep();
        #1;
        checkOutputs(tag);
    endtask

    task automatic run(input string tag, input int n);
        repeat (n) step(tag);
    endtask

    task automatic pulse(input string tag, input bit snz, input bit dis);
        snooze_p  = snz;
        dismiss_p = dis;
        step(tag);
        snooze_p  = 1'b0;
        dismiss_p = 1'b0;
    endtask

    initial begin
        modelReset();
        #12;
        checkOutputs("reset");
        @(negedge clk);
        RESET_n = 1'b1;
        run("idle", 3);

        // Basic ring, blink and timeout, then DONE until the minute changes.
        cur_time = ALARM;
        step("trigger");
        check("trigger_latency", ringing, 1'b1);
        run("ringing", 29);
        check("ring_last_cycle", ringing, 1'b1);
        step("ring_timeout");
        check("ring_timeout", ringing, 1'b0);
        run("done_hold", 5);
        cur_time = OTHER;
        run("to_idle", 3);

        // Snooze twice, third snooze ignored.
        cur_time = ALARM;
        run("ring2", 5);
        pulse("snooze1", 1'b1, 1'b0);
        check("snooze1_cnt", snooze_cnt, 2'd1);
        check("snooze1_led", led, 1'b1);
        run("snoozing1", 39);
        check("snooze_last_cycle", snoozing, 1'b1);
        step("re_ring1");
        check("re_ring1", ringing, 1'b1);
        run("ring3", 3);
        pulse("snooze2", 1'b1, 1'b0);
        check("snooze2_cnt", snooze_cnt, 2'd2);
        run("snoozing2", 41);
        pulse("snooze3_ignored", 1'b1, 1'b0);
        check("snooze3_ignored", ringing, 1'b1);
        run("ring_out", 32);
        cur_time = OTHER;
        run("to_idle2", 3);

        // Dismiss and snooze in the same cycle: dismiss wins.
        cur_time = ALARM;
        run("ring4", 3);
        pulse("dismiss_snooze", 1'b1, 1'b1);
        check("dismiss_wins_cnt", snooze_cnt, 2'd0);
        run("dismissed", 4);
        cur_time = OTHER;
        run("to_idle3", 3);

        // Disarm during snooze.
        cur_time = ALARM;
        run("ring5", 3);
        pulse("snooze_then_disarm", 1'b1, 1'b0);
        run("snoozing3", 5);
        armed = 1'b0;
        step("disarm");
        check("disarm_snoozing", snoozing, 1'b0);
        run("disarmed", 50);
        cur_time = OTHER;
        step("disarm_idle");
        check("disarm_idle_cnt", snooze_cnt, 2'd0);
        armed = 1'b1;
        run("idle4", 2);

        // clk_mode low at match, then raised while match holds: no ring.
        clk_mode = 1'b0;
        cur_time = ALARM;
        run("mode_off", 3);
        clk_mode = 1'b1;
        run("mode_on_late", 3);
        check("no_late_trigger", ringing, 1'b0);
        cur_time = OTHER;
        run("idle5", 2);

        // Asynchronous reset mid-ring, released while match still holds.
        cur_time = ALARM;
        run("ring6", 4);
        #2;
        RESET_n = 1'b0;
        #1;
        modelReset();
        check("async_reset_melody", melody_en, 1'b0);
        check("async_reset_led", led, 1'b0);
        @(negedge clk);
        @(negedge clk);
        RESET_n = 1'b1;
        run("post_reset", 5);
        check("no_retrigger_after_reset", ringing, 1'b0);
        cur_time = OTHER;
        run("idle6", 2);

        // Random traffic around the alarm minute.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) cur_time = (cur_time == ALARM) ? OTHER : ALARM;
            armed     = ($urandom_range(0, 299) != 0);
            clk_mode  = ($urandom_range(0, 249) != 0);
            snooze_p  = ($urandom_range(0, 24) == 0);
            dismiss_p = ($urandom_range(0, 99) == 0);
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
